// File: rtl/window_sum_acc.sv
// window_sum_acc: running signed sum over the last N accepted samples.
// Ports: CLK, ACLR (async, active high), START, WIN_LEN, IN_VALID, D,
//        DLY (delay line tap Q), SR_CE, SR_A (delay line control),
//        SUM, SUM_VALID, FULL.
module window_sum_acc #(
    parameter int C_WIDTH      = 16,
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_ACC_WIDTH  = C_WIDTH + C_ADDR_WIDTH
) (
    input  logic                    CLK,
    input  logic                    ACLR,
    input  logic                    START,
    input  logic [C_ADDR_WIDTH-1:0] WIN_LEN,
    input  logic                    IN_VALID,
    input  logic [C_WIDTH-1:0]      D,
    input  logic [C_WIDTH-1:0]      DLY,
    output logic                    SR_CE,
    output logic [C_ADDR_WIDTH-1:0] SR_A,
    output logic [C_ACC_WIDTH-1:0]  SUM,
    output logic                    SUM_VALID,
    output logic                    FULL
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN
    } state_t;

    localparam int EXT_W = C_ACC_WIDTH - C_WIDTH;

    state_t                  state_q, state_d;
    logic [C_ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [C_ACC_WIDTH-1:0]  sum_q, sum_d;
    logic [C_ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [C_ADDR_WIDTH-1:0] len_q, len_d;
    logic                    sv_q, sv_d;
    logic                    full_q, full_d;
    logic                    accept;
    logic [C_ACC_WIDTH-1:0]  d_ext;
    logic [C_ACC_WIDTH-1:0]  dly_ext;
    logic [C_ADDR_WIDTH:0]   cnt_one;
    logic [C_ADDR_WIDTH:0]   last_cnt;

    assign d_ext    = {{EXT_W{D[C_WIDTH-1]}}, D};
    assign dly_ext  = {{EXT_W{DLY[C_WIDTH-1]}}, DLY};
    assign cnt_one  = {{C_ADDR_WIDTH{1'b0}}, 1'b1};
    assign last_cnt = {1'b0, len_q};

    // A sample is taken only once a window has been armed by START,
    // and never in the START cycle itself.
    assign accept = IN_VALID && !START && (state_q != S_IDLE);

    // Combinational so the delay line shifts on the same edge the
    // sample is accumulated; tap len_q then yields the sample that
    // falls out of the window.
    assign SR_CE     = accept;
    assign SR_A      = len_q;
    assign SUM       = sum_q;
    assign SUM_VALID = sv_q;
    assign FULL      = full_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sv_d    = 1'b0;
        full_d  = full_q;
        if (START) begin
            state_d = S_FILL;
            len_d   = WIN_LEN;
            acc_d   = '0;
            cnt_d   = '0;
            full_d  = 1'b0;
        end else if (accept) begin
            unique case (state_q)
                // DLY is stale until the window is primed, so it is
                // not subtracted while filling.
                S_FILL: begin
                    acc_d = acc_q + d_ext;
                    cnt_d = cnt_q + cnt_one;
                    if (cnt_q == last_cnt) begin
                        full_d  = 1'b1;
                        sum_d   = acc_d;
                        sv_d    = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d = acc_q + d_ext - dly_ext;
                    sum_d = acc_d;
                    sv_d  = 1'b1;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sv_q    <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sv_q    <= sv_d;
            full_q  <= full_d;
        end
    end

endmodule
